// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked execute-stage ALU with registered results and iterative mulu/divu/remu
module seq_alu #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [DWIDTH-1:0] rs1,
    input  logic [DWIDTH-1:0] rs2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] rd,
    output logic              zero,
    output logic              overflow,
    output logic              busy
);
    localparam int SW = $clog2(DWIDTH);
    localparam logic [SW-1:0] CNT_LAST = SW'(DWIDTH - 1);

    localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011, OP_SRL = 4'b0100, OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000, OP_DIV = 4'b1001, OP_REM = 4'b1010;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [DWIDTH-1:0] b_q, b_d;
    logic [DWIDTH-1:0] hi_q, hi_d;
    logic [DWIDTH-1:0] lo_q, lo_d;
    logic [DWIDTH-1:0] rd_q, rd_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;

    logic [DWIDTH-1:0] alu_rd;
    logic              alu_ovf;
    logic              alu_vld;
    logic              is_iter;
    logic [DWIDTH-1:0] sum, diff;
    logic [SW-1:0]     shamt;

    assign sum   = rs1 + rs2;
    assign diff  = rs1 - rs2;
    assign shamt = rs2[SW-1:0];

    // Single-cycle results, including the divide-by-zero shortcut
    always_comb begin
        alu_rd  = '0;
        alu_ovf = 1'b0;
        alu_vld = 1'b1;
        case (op)
            OP_AND: alu_rd = rs1 & rs2;
            OP_OR:  alu_rd = rs1 | rs2;
            OP_NOR: alu_rd = ~(rs1 | rs2);
            OP_ADD: begin
                alu_rd  = sum;
                alu_ovf = (rs1[DWIDTH-1] == rs2[DWIDTH-1]) && (sum[DWIDTH-1] != rs1[DWIDTH-1]);
            end
            OP_SUB: begin
                alu_rd  = diff;
                alu_ovf = (rs1[DWIDTH-1] != rs2[DWIDTH-1]) && (diff[DWIDTH-1] != rs1[DWIDTH-1]);
            end
            OP_SLT: alu_rd = {{(DWIDTH-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
            OP_SLL: alu_rd = rs1 << shamt;
            OP_SRL: alu_rd = rs1 >> shamt;
            OP_SRA: alu_rd = $signed(rs1) >>> shamt;
            OP_DIV: alu_rd = '1;
            OP_REM: alu_rd = rs1;
            default: alu_vld = 1'b0;
        endcase
    end

    assign is_iter = (op == OP_MUL) || (((op == OP_DIV) || (op == OP_REM)) && (rs2 != '0));

    // Shift-add multiply: {hi,lo} shifts right, multiplier bits consumed from lo[0]
    logic [DWIDTH:0]   mul_sum;
    logic [DWIDTH-1:0] mul_hi, mul_lo;
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign mul_hi  = mul_sum[DWIDTH:1];
    assign mul_lo  = {mul_sum[0], lo_q[DWIDTH-1:1]};

    // Restoring divide: hi holds the partial remainder, lo shifts dividend out and quotient in
    logic [DWIDTH:0]   div_shift, div_trial;
    logic [DWIDTH-1:0] div_hi, div_lo;
    assign div_shift = {hi_q, lo_q[DWIDTH-1]};
    assign div_trial = div_shift - {1'b0, b_q};
    assign div_hi    = div_trial[DWIDTH] ? div_shift[DWIDTH-1:0] : div_trial[DWIDTH-1:0];
    assign div_lo    = {lo_q[DWIDTH-2:0], ~div_trial[DWIDTH]};

    logic [DWIDTH-1:0] fin_rd;
    always_comb begin
        fin_rd = div_lo;
        if (op_q == OP_MUL)      fin_rd = mul_lo;
        else if (op_q == OP_REM) fin_rd = div_hi;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rd_d    = rd_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d = op;
                    if (is_iter) begin
                        state_d = S_BUSY;
                        cnt_d   = '0;
                        hi_d    = '0;
                        b_d     = (op == OP_MUL) ? rs1 : rs2;
                        lo_d    = (op == OP_MUL) ? rs2 : rs1;
                    end else begin
                        state_d = S_DONE;
                        rd_d    = alu_rd;
                        zero_d  = alu_vld && (alu_rd == '0);
                        ovf_d   = alu_ovf;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + SW'(1);
                hi_d  = (op_q == OP_MUL) ? mul_hi : div_hi;
                lo_d  = (op_q == OP_MUL) ? mul_lo : div_lo;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    rd_d    = fin_rd;
                    zero_d  = (fin_rd == '0);
                    ovf_d   = (op_q == OP_MUL) && (mul_hi != '0);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rd_q    <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rd_q    <= rd_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign rd        = rd_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu against an arithmetic reference model
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] rs1, rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rd;
    logic        zero, overflow, busy;

    int tests = 0;
    int fails = 0;

    seq_alu #(.DWIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready),
        .rd(rd), .zero(zero), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z, output logic v,
                                  output bit iter);
        longint s;
        logic [63:0] p;
        bit valid;
        valid = 1; v = 0; iter = 0; r = 0;
        case (o)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0010: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = a + b; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r = a - b; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = a << b[4:0];
            4'b0100: r = a >> b[4:0];
            4'b0101: r = $signed(a) >>> b[4:0];
            4'b1000: begin
                p = {32'b0, a} * {32'b0, b};
                r = p[31:0]; v = (p[63:32] != 0); iter = 1;
            end
            4'b1001: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; iter = (b != 0); end
            4'b1010: begin r = (b == 0) ? a : a % b; iter = (b != 0); end
            default: valid = 0;
        endcase
        z = valid && (r == 0);
    endfunction

    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic ez, ev;
        bit it;
        int lat, bcnt;
        model(o, a, b, er, ez, ev, it);
        @(negedge clk);
        chk({tag, ".in_ready"}, in_ready, 1);
        in_valid = 1; op = o; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        in_valid = 0; op = 4'($urandom); rs1 = $urandom; rs2 = $urandom;
        lat = 1; bcnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, it ? 33 : 1);
        if (it) chk({tag, ".busy_cycles"}, bcnt, 32);
        chk({tag, ".rd"}, rd, er);
        chk({tag, ".zero"}, zero, ez);
        chk({tag, ".overflow"}, overflow, ev);
        @(negedge clk); out_ready = 1;
        @(posedge clk); #1; out_ready = 0;
        chk({tag, ".idle_ready"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        logic [31:0] hold_rd;
        logic hold_z, hold_v;
        rstn = 0; in_valid = 0; out_ready = 0; op = 0; rs1 = 0; rs2 = 0;
        #1;
        chk("reset.flags", {in_ready, out_valid, busy, zero, overflow}, 5'b10000);
        chk("reset.rd", rd, 0);
        repeat (2) @(negedge clk);
        rstn = 1;

        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1);
        run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h1);
        run_op("mul_hi", 4'b1000, 32'h0001_0000, 32'h0001_0000);
        run_op("mul_7x6", 4'b1000, 32'd7, 32'd6);
        run_op("divu", 4'b1001, 32'd100, 32'd7);
        run_op("remu", 4'b1010, 32'd100, 32'd7);
        run_op("divu0", 4'b1001, 32'd5, 32'd0);
        run_op("remu0", 4'b1010, 32'd5, 32'd0);
        run_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'd1);
        run_op("slt_pos", 4'b0111, 32'd1, 32'hFFFF_FFFF);
        run_op("sra", 4'b0101, 32'h8000_0000, 32'd4);
        run_op("srl", 4'b0100, 32'h8000_0000, 32'd4);
        run_op("invalid", 4'b1111, 32'h1234, 32'h5678);
        run_op("nor", 4'b1100, 32'h0F0F_0000, 32'h00F0_FFFF);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 6) == 0) ? 32'd0 : (($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            run_op($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), a, b);
        end

        // Backpressure: result must hold and new requests must be ignored
        @(negedge clk);
        in_valid = 1; op = 4'b0010; rs1 = 32'd10; rs2 = 32'd20;
        @(posedge clk); #1;
        op = 4'b0001; rs1 = 32'hFFFF; rs2 = 32'h1;
        hold_rd = rd; hold_z = zero; hold_v = overflow;
        chk("bp.first", {out_valid, rd}, {1'b1, 32'd30});
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp.hold%0d", i), {out_valid, in_ready, rd, zero, overflow},
                {1'b1, 1'b0, hold_rd, hold_z, hold_v});
        end
        @(negedge clk); in_valid = 0; out_ready = 1;
        @(posedge clk); #1; out_ready = 0;
        chk("bp.release", {in_ready, out_valid, rd}, {1'b1, 1'b0, 32'd30});

        // Asynchronous reset mid-multiply
        @(negedge clk);
        in_valid = 1; op = 4'b1000; rs1 = 32'd123; rs2 = 32'd456;
        @(posedge clk); #1; in_valid = 0;
        repeat (9) @(posedge clk);
        #3;
        chk("rst.busy_before", busy, 1);
        rstn = 0; #1;
        chk("rst.flags", {in_ready, out_valid, busy, zero, overflow}, 5'b10000);
        chk("rst.rd", rd, 0);
        @(negedge clk); rstn = 1;
        run_op("post_rst_add", 4'b0010, 32'd2, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
